// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: push-button conditioner for one board button.
// Synchronises btnRaw, samples it on an internal divide-by-TICK_DIV tick,
// accepts a new level after STABLE_TICKS matching ticks and emits a clean
// level plus one-cycle press/release strobes.
//
// Ports:
//   clkIn      - system clock
//   reset      - asynchronous, active-low reset
//   btnRaw     - raw asynchronous active-high button input
//   btnLevel   - debounced level
//   btnPress   - one-cycle strobe on accepted press (and on auto-repeat)
//   btnRelease - one-cycle strobe on accepted release
//
// Optional build macro: AUTO_REPEAT_EN adds press auto-repeat while held
// (first repeat REPEAT_DELAY ticks after acceptance, then every REPEAT_RATE).
`timescale 1ns/1ps
module button_debounce_fsm #(
  parameter int unsigned TICK_DIV     = 6,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic clkIn,
  input  logic reset,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = 8;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_TICKS);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  // Elaboration-time parameter range check
  if (TICK_DIV < 2 || TICK_DIV > 65536 || STABLE_TICKS < 1 || STABLE_TICKS > 255 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
    $error("button_debounce_fsm: parameter out of range");
  end

  logic              s1_q, s2_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick_c;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;

  // Two-flop synchroniser; only s2_q is used downstream
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btnRaw;
      s2_q <= s1_q;
    end
  end

  // Free-running sample tick, high in the last count of each period
  assign tick_c = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else if (tick_c) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Stable counter increment, saturating at STABLE_TICKS
  assign cnt_inc_c = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d, rep_inc_c, rep_target_c;
  logic             rep_first_q, rep_first_d;

  // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks
  assign rep_inc_c    = rep_q + CNT_W'(1);
  assign rep_target_c = rep_first_q ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  // Without auto-repeat a press strobe comes only from acceptance.
`endif

  // State, counter and output registers
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic; everything advances only on tick cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    if (tick_c) begin
      case (state_q)
        S_IDLE, S_PRESS_WAIT: begin
          if (s2_q) begin
            // cnt_q is 0 in IDLE, so STABLE_TICKS=1 accepts on the first tick
            if (cnt_inc_c == STABLE_MAX) begin
              state_d = S_PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
`ifdef AUTO_REPEAT_EN
              rep_d       = '0;
              rep_first_d = 1'b1;
`endif
            end else begin
              state_d = S_PRESS_WAIT;
              cnt_d   = cnt_inc_c;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED, S_RELEASE_WAIT: begin
          if (!s2_q) begin
            if (cnt_inc_c == STABLE_MAX) begin
              state_d   = S_IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = S_RELEASE_WAIT;
              cnt_d   = cnt_inc_c;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
            // Repeat counter only runs on ticks spent in PRESSED
            if (state_q == S_PRESSED) begin
              if (rep_inc_c == rep_target_c) begin
                press_d     = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b0;
              end else begin
                rep_d = rep_inc_c;
              end
            end
`endif
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  assign btnLevel   = level_q;
  assign btnPress   = press_q;
  assign btnRelease = release_q;

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Testbench for button_debounce_fsm at default parameters. A run-length
// model of the debounce rules is checked every cycle; directed scenarios
// pin exact latencies, strobe counts and reset behaviour.
`timescale 1ns/1ps
module tb_button_debounce_fsm;

  localparam int TD = 6;
  localparam int ST = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic clkIn = 1'b0;
  logic reset;
  logic btnRaw;
  logic btnLevel, btnPress, btnRelease;

  int checks   = 0;
  int failures = 0;

  button_debounce_fsm #(
    .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clkIn(clkIn), .reset(reset), .btnRaw(btnRaw),
    .btnLevel(btnLevel), .btnPress(btnPress), .btnRelease(btnRelease)
  );

  always #5 clkIn = ~clkIn;

  // Behavioural model: the level flips once ST consecutive tick samples of
  // the two-cycle-delayed button disagree with it.
  int   cyc = 0;
  logic h1 = 1'b0, h2 = 1'b0;
  logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  int   m_run = 0, m_held = 0;

  task model_step();
    logic smp;
    if (!reset) begin
      cyc = 0; h1 = 1'b0; h2 = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
      m_run = 0; m_held = 0;
    end else begin
      cyc++;
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (cyc % TD == 0) begin
        smp = h2;
        if (smp != m_level) begin
          m_run++;
          if (m_run >= ST) begin
            m_level = smp;
            m_run   = 0;
            if (smp) begin
              m_press = 1'b1;
              m_held  = 0;
            end else begin
              m_rel = 1'b1;
            end
          end
        end else begin
`ifdef AUTO_REPEAT_EN
          if (m_level && m_run == 0) begin
            m_held++;
            if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) m_press = 1'b1;
          end
`endif
          m_run = 0;
        end
      end
      h2 = h1;
      h1 = btnRaw;
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clkIn);
      #1;
      model_step();
      checks++;
      if (btnLevel !== m_level || btnPress !== m_press || btnRelease !== m_rel) begin
        failures++;
        $display("FAIL model_cycle cyc=%0d: got level/press/release=%b%b%b expected %b%b%b",
                 cyc, btnLevel, btnPress, btnRelease, m_level, m_press, m_rel);
      end
    end
  end

  // Directed-scenario tallies
  int n_press, n_rel;
  bit saw_hi, saw_lo;

  task clear_tally();
    n_press = 0; n_rel = 0; saw_hi = 1'b0; saw_lo = 1'b0;
  endtask

  task observe();
    if (btnPress === 1'b1) n_press++;
    if (btnRelease === 1'b1) n_rel++;
    if (btnLevel === 1'b1) saw_hi = 1'b1; else saw_lo = 1'b1;
  endtask

  task chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task hold(input logic v, input int n);
    @(negedge clkIn);
    btnRaw = v;
    repeat (n) begin
      @(posedge clkIn);
      #2;
      observe();
    end
  endtask

  // Counts posedges after the current point until btnLevel == v; -1 on timeout
  task wait_level(input logic v, input int budget, output int k);
    int i;
    i = 0;
    k = -1;
    while (k < 0 && i < budget) begin
      i++;
      @(posedge clkIn);
      #2;
      observe();
      if (btnLevel === v) k = i;
    end
  endtask

  task wait_press(input int budget, output int k);
    int i;
    i = 0;
    k = -1;
    while (k < 0 && i < budget) begin
      i++;
      @(posedge clkIn);
      #2;
      observe();
      if (btnPress === 1'b1) k = i;
    end
  endtask

  // Stop just after a posedge that lands on a tick boundary
  task align();
    int g;
    g = 0;
    @(posedge clkIn);
    #2;
    while ((cyc % TD) != 0 && g < 2 * TD) begin
      @(posedge clkIn);
      #2;
      g++;
    end
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    btnRaw = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clkIn);
    chk("reset_level", int'(btnLevel), 0);
    chk("reset_press", int'(btnPress), 0);
    chk("reset_release", int'(btnRelease), 0);

    // Clean press together with reset release: ticks at edges 6,12,18,24
    btnRaw = 1'b1;
    reset  = 1'b1;
    clear_tally();
    wait_level(1'b1, 60, k);
    chk("clean_edges_to_level", k, 24);
    chk_range("clean_latency_cycles", k + 1, 22, 27);
    chk("clean_press_same_cycle", int'(btnPress), 1);
    chk("clean_press_count", n_press, 1);
`ifdef AUTO_REPEAT_EN
    wait_press(60, k);
    chk("repeat_first_gap", k, 48);
    wait_press(40, k);
    chk("repeat_next_gap", k, 24);
    clear_tally();
    hold(1'b1, 150);
    chk("held_no_release", n_rel, 0);
    chk("held_level_stays", int'(saw_lo), 0);
`else
    clear_tally();
    hold(1'b1, 250);
    chk("held_single_press", n_press, 0);
    chk("held_no_release", n_rel, 0);
    chk("held_level_stays", int'(saw_lo), 0);
`endif

    // Release with 12-cycle bounce ending on a 1->0 edge
    align();
    clear_tally();
    hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
    chk("release_bounce_level_held", int'(saw_lo), 0);
    chk("release_bounce_no_strobe", n_rel, 0);
    @(negedge clkIn);
    btnRaw = 1'b0;
    wait_level(1'b0, 60, k);
    chk("release_edges_to_level", k, 24);
    chk("release_strobe_same_cycle", int'(btnRelease), 1);
    chk("release_no_press", int'(btnPress), 0);
    clear_tally();
    hold(1'b0, 30);
    chk("release_strobe_single", n_rel, 0);

    // Glitch: 10-cycle high pulse never qualifies
    clear_tally();
    hold(1'b1, 10);
    hold(1'b0, 60);
    chk("glitch_no_press", n_press, 0);
    chk("glitch_no_release", n_rel, 0);
    chk("glitch_level_low", int'(saw_hi), 0);

    // Bouncy press: toggles every 5 cycles for 60 cycles, then held
    align();
    clear_tally();
    for (int i = 0; i < 12; i++) hold((i % 2) == 0, 5);
    chk("bounce_level_low", int'(saw_hi), 0);
    chk("bounce_no_press", n_press, 0);
    @(negedge clkIn);
    btnRaw = 1'b1;
    wait_level(1'b1, 60, k);
    chk("bounce_edges_to_level", k, 24);
    chk("bounce_press_same_cycle", int'(btnPress), 1);
    clear_tally();
    hold(1'b1, 30);
    chk("bounce_single_press", n_press, 0);

    // Reset while pressed and held: outputs drop at once, no release strobe
    @(negedge clkIn);
    reset = 1'b0;
    #1;
    chk("rst_pressed_level", int'(btnLevel), 0);
    chk("rst_pressed_press", int'(btnPress), 0);
    chk("rst_pressed_release", int'(btnRelease), 0);
    clear_tally();
    repeat (3) begin
      @(posedge clkIn);
      #2;
      observe();
    end
    @(negedge clkIn);
    reset = 1'b1;
    wait_level(1'b1, 28, k);
    chk("rst_requal_edges", k, 24);
    chk("rst_requal_press", int'(btnPress), 1);
    chk("rst_no_release", n_rel, 0);
    hold(1'b1, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t expected bench completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
